// File: rtl/instr_sequencer.sv
// Instruction issuer for the control unit: buffers loader words in a FIFO and steps each instruction through count 00..11.
// Latency: run seen in IDLE at cycle N -> FETCH at N+1, count 00..11 on N+2..N+5, next FETCH or done at N+6; LDI adds FETCH_IMM.
// Backpressure: wr_ready = !full, so the loader stalls while the FIFO is full. Macro ILLEGAL_SKIP_EN makes the sequencer skip opcodes 011/110 and pulse illegal.

// Small synchronous FIFO; pointers wrap modulo DEPTH, occupancy is exposed as cnt.
module seq_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 9
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     in_vld,
   output logic                     in_rdy,
   input  logic [W-1:0]             in_dat,
   input  logic                     out_pop,
   output logic [W-1:0]             out_dat,
   output logic [$clog2(DEPTH):0]   cnt
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          push;

   assign in_rdy  = (cnt != FULL_CNT);
   assign push    = in_vld && in_rdy;
   assign out_dat = mem[rd_ptr];

   // Pointer and occupancy tracking; simultaneous push and pop leave cnt unchanged.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push)    wr_ptr <= wr_ptr + PW'(1);
         if (out_pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, out_pop})
            2'b10:   cnt <= cnt + (PW+1)'(1);
            2'b01:   cnt <= cnt - (PW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage array; contents need no reset because the pointers gate visibility.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= in_dat;
   end
endmodule

module instr_sequencer #(
   parameter int DEPTH = 4,
   parameter int IW    = 9
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic [IW-1:0] wr_data,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic          run,
   output logic [IW-1:0] instr,
   output logic [1:0]    count,
   output logic [IW-1:0] imm,
   output logic          busy,
   output logic          done,
   output logic          empty,
   output logic          full,
   output logic          illegal
);
   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, FETCH_IMM, EXEC} state_t;

   state_t        state_q;
   state_t        state_d;
   logic [1:0]    step_q;
   logic [IW-1:0] head;
   logic [PW:0]   cnt;
   logic          fifo_rdy;
   logic          pop;
   logic          is_ldi;
   logic          is_bad;
   logic          more;
   logic          skip_idle;
   logic          exec_last;

   seq_fifo #(.DEPTH(DEPTH), .W(IW)) u_fifo (
      .clock   (clock),
      .resetn  (resetn),
      .in_vld  (wr_valid),
      .in_rdy  (fifo_rdy),
      .in_dat  (wr_data),
      .out_pop (pop),
      .out_dat (head),
      .cnt     (cnt)
   );

   assign wr_ready  = fifo_rdy;
   assign full      = !fifo_rdy;
   assign empty     = (cnt == '0);
   assign is_ldi    = (head[IW-1:IW-3] == 3'b101);
   assign exec_last = (state_q == EXEC) && (step_q == 2'b11);

`ifdef ILLEGAL_SKIP_EN
   logic illegal_q;
   logic skip_idle_q;

   assign is_bad    = (head[IW-1:IW-3] == 3'b011) || (head[IW-1:IW-3] == 3'b110);
   // A skipped word leaves data for another FETCH only if it was not the last one or a push lands now.
   assign more      = (cnt > (PW+1)'(1)) || (wr_valid && fifo_rdy);
   assign illegal   = illegal_q;
   assign skip_idle = skip_idle_q;

   // Flag a skipped opcode; when the skip ends the run, done follows one cycle after illegal.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         illegal_q   <= 1'b0;
         skip_idle_q <= 1'b0;
      end else begin
         illegal_q   <= (state_q == FETCH) && is_bad;
         skip_idle_q <= (state_q == FETCH) && is_bad && !(run && more);
      end
   end
`else
   assign is_bad    = 1'b0;
   assign more      = 1'b0;
   assign illegal   = 1'b0;
   assign skip_idle = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (run && !empty) state_d = FETCH;
         FETCH: begin
            if (is_bad)      state_d = (run && more) ? FETCH : IDLE;
            else if (is_ldi) state_d = FETCH_IMM;
            else             state_d = EXEC;
         end
         FETCH_IMM: if (!empty) state_d = EXEC;
         EXEC:      if (step_q == 2'b11) state_d = (run && !empty) ? FETCH : IDLE;
      endcase
   end

   // Outputs decoded from state; count reads 00 outside EXEC.
   always_comb begin
      busy  = (state_q != IDLE);
      count = (state_q == EXEC) ? step_q : 2'b00;
      pop   = (state_q == FETCH) || ((state_q == FETCH_IMM) && !empty);
   end

   // Datapath: latch instruction/immediate on pop, run the step counter, pulse done on return to IDLE.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         instr  <= '0;
         imm    <= '0;
         step_q <= 2'b00;
         done   <= 1'b0;
      end else begin
         if ((state_q == FETCH) && !is_bad)      instr <= head;
         if ((state_q == FETCH_IMM) && !empty)   imm   <= head;
         step_q <= (state_q == EXEC) ? step_q + 2'b01 : 2'b00;
         done   <= (exec_last && !(run && !empty)) || skip_idle;
      end
   end
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: hand-computed cycle-by-cycle expectations.
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: exercises the full FIFO and the FETCH_IMM wait on an empty queue.
module tb_instr_sequencer;
   logic       clock;
   logic       resetn;
   logic [8:0] wr_data;
   logic       wr_valid;
   logic       wr_ready;
   logic       run;
   logic [8:0] instr;
   logic [1:0] count;
   logic [8:0] imm;
   logic       busy;
   logic       done;
   logic       empty;
   logic       full;
   logic       illegal;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [8:0] SUM = 9'b000_001_010;
   localparam logic [8:0] LDI = 9'b101_011_000;
   localparam logic [8:0] BAD = 9'b011_000_000;
   localparam logic [8:0] SUB = 9'b001_010_011;
   localparam logic [8:0] WA  = 9'b010_001_001;
   localparam logic [8:0] WB  = 9'b000_010_010;
   localparam logic [8:0] WC  = 9'b100_110_001;

   logic [8:0] wq [5];

   instr_sequencer #(.DEPTH(4), .IW(9)) dut (
      .clock    (clock),
      .resetn   (resetn),
      .wr_data  (wr_data),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .run      (run),
      .instr    (instr),
      .count    (count),
      .imm      (imm),
      .busy     (busy),
      .done     (done),
      .empty    (empty),
      .full     (full),
      .illegal  (illegal)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [8:0] w);
      wr_data  = w;
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
   endtask

   initial begin
      clock = 1'b0; resetn = 1'b0; wr_data = '0; wr_valid = 1'b0; run = 1'b0;
      wq[0] = 9'b000_111_000; wq[1] = 9'b001_000_111;
      wq[2] = 9'b010_101_010; wq[3] = 9'b100_010_101; wq[4] = 9'b111_111_111;
      #2;
      check("rst_instr", instr, 0);
      check("rst_imm", imm, 0);
      check("rst_count", count, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_illegal", illegal, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_wr_ready", wr_ready, 1);
      #10 resetn = 1'b1;
      tick(); tick();

      // single SUM instruction
      push(SUM); run = 1'b1;
      tick(); check("sum_fetch_busy", busy, 1); check("sum_fetch_count", count, 0);
      for (int j = 0; j < 4; j++) begin
         tick(); check("sum_instr", instr, SUM); check("sum_count", count, j);
      end
      tick(); check("sum_done", done, 1); check("sum_idle_busy", busy, 0);
      run = 1'b0;
      tick(); check("sum_done_clr", done, 0);

      // LDI with immediate already queued
      push(LDI); push(9'h05A); run = 1'b1;
      tick(); check("ldi_fetch_busy", busy, 1);
      tick(); check("ldi_fimm_count", count, 0); check("ldi_fimm_instr", instr, LDI);
      tick(); check("ldi_imm", imm, 9'h05A); check("ldi_exec0", count, 0); check("ldi_instr", instr, LDI);
      for (int j = 1; j < 4; j++) begin
         tick(); check("ldi_count", count, j);
      end
      tick(); check("ldi_done", done, 1); check("ldi_empty", empty, 1);
      run = 1'b0;
      tick();

      // LDI waiting for its immediate
      push(LDI); run = 1'b1;
      tick(); tick();
      for (int j = 0; j < 3; j++) begin
         check("wait_busy", busy, 1); check("wait_count", count, 0);
         tick();
      end
      push(9'h1FF);
      check("wait_last_count", count, 0); check("wait_last_busy", busy, 1);
      tick(); check("wait_imm", imm, 9'h1FF); check("wait_exec0", count, 0);
      for (int j = 1; j < 4; j++) begin
         tick(); check("wait_count_step", count, j);
      end
      tick(); check("wait_done", done, 1);
      run = 1'b0;
      tick();

      // fill to full, fifth word dropped, then drain back-to-back
      wr_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wr_data = wq[k]; tick();
      end
      check("fill_full", full, 1); check("fill_wr_ready", wr_ready, 0);
      wr_data = wq[4]; tick(); wr_valid = 1'b0;
      check("fill_still_full", full, 1);
      run = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick(); check("b2b_fetch_busy", busy, 1); check("b2b_fetch_count", count, 0);
         check("b2b_no_done", done, 0);
         for (int j = 0; j < 4; j++) begin
            tick(); check("b2b_instr", instr, wq[k]); check("b2b_count", count, j);
         end
      end
      tick(); check("b2b_done", done, 1); check("b2b_empty", empty, 1); check("b2b_busy", busy, 0);
      run = 1'b0;
      tick();

      // undefined opcode followed by SUB
      push(BAD); push(SUB); run = 1'b1;
      tick();
`ifdef ILLEGAL_SKIP_EN
      tick(); check("skip_illegal", illegal, 1); check("skip_instr_hold", instr, wq[3]);
      check("skip_count", count, 0); check("skip_busy", busy, 1); check("skip_no_done", done, 0);
      tick(); check("skip_illegal_clr", illegal, 0); check("skip_sub", instr, SUB); check("skip_sub0", count, 0);
      for (int j = 1; j < 4; j++) begin
         tick(); check("skip_sub_count", count, j);
      end
      tick(); check("skip_done", done, 1); check("skip_done_illegal", illegal, 0);
`else
      for (int j = 0; j < 4; j++) begin
         tick(); check("bad_instr", instr, BAD); check("bad_count", count, j); check("bad_illegal", illegal, 0);
      end
      tick(); check("bad_next_fetch", busy, 1); check("bad_next_count", count, 0);
      for (int j = 0; j < 4; j++) begin
         tick(); check("bad_sub", instr, SUB); check("bad_sub_count", count, j);
      end
      tick(); check("bad_done", done, 1); check("bad_illegal_end", illegal, 0);
`endif
      run = 1'b0;
      tick();

      // asynchronous reset in the middle of EXEC
      push(WA); push(WB); run = 1'b1;
      tick(); tick(); tick(); tick();
      check("mid_count_pre", count, 2);
      #2 resetn = 1'b0;
      #1;
      check("mid_rst_count", count, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_empty", empty, 1);
      check("mid_rst_wr_ready", wr_ready, 1);
      check("mid_rst_instr", instr, 0);
      #3 resetn = 1'b1;
      for (int j = 0; j < 4; j++) begin
         tick(); check("post_rst_idle", busy, 0); check("post_rst_count", count, 0);
      end
      push(WC);
      check("post_push_idle", busy, 0);
      tick(); check("post_push_fetch", busy, 1);
      tick(); check("post_push_instr", instr, WC); check("post_push_count", count, 0);
      run = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
